// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential word fetches, buffers {instr, pc}.
// Optional build macro FETCH_QUEUE_BYPASS_EN presents a response into an empty queue in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr_F,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4_F,
    input  logic        PCSrc,
    input  logic [31:0] PCTargetE
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;
    localparam logic [OUT_W-1:0] MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0] DEPTH_C    = SUM_W'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_LAST_C = TAG_W'(MAX_OUTSTANDING - 1);

    logic [31:0]      fetch_pc_r;
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pc_mem_r    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      tag_mem_r   [MAX_OUTSTANDING];
    logic [TAG_W-1:0] tag_wr_r;
    logic [TAG_W-1:0] tag_rd_r;
    logic [OUT_W-1:0] inflight_r;
    logic [OUT_W-1:0] drop_cnt_r;

    logic             req_fire_s;
    logic             rsp_live_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;
    logic             fifo_nonempty_s;
    logic [31:0]      rsp_pc_s;
    logic [SUM_W-1:0] reserved_s;
    logic             unused_target_lsb_s;

    // Wrap-around increment for the PC-tag ring, whose depth need not be a power of two.
    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] ptr);
        logic [TAG_W-1:0] nxt;
        if (ptr == TAG_LAST_C) begin
            nxt = TAG_W'(0);
        end else begin
            nxt = ptr + TAG_W'(1);
        end
        return nxt;
    endfunction

    assign unused_target_lsb_s = ^PCTargetE[1:0];
    assign imem_addr           = fetch_pc_r;
    assign reserved_s          = SUM_W'(count_r) + SUM_W'(inflight_r);

    // Request gating: slots are reserved for every in-flight response so a response is never refused.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!reset && !PCSrc && (inflight_r < MAX_OUT_C) && (reserved_s < DEPTH_C)) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
    end

    // Handshake decode: a response is live only when it is not a leftover from before a redirect.
    always_comb begin
        req_fire_s      = imem_req_valid && imem_req_ready;
        rsp_live_s      = imem_rsp_valid && !PCSrc && (drop_cnt_r == OUT_W'(0));
        rsp_pc_s        = tag_mem_r[tag_rd_r];
        fifo_nonempty_s = (count_r != CNT_W'(0));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s        = rsp_live_s && !fifo_nonempty_s;
`else
        bypass_s        = 1'b0;
`endif
        pop_s           = fifo_nonempty_s && instr_ready && !PCSrc;
        push_s          = rsp_live_s && !(bypass_s && instr_ready);
    end

    // Head presentation: bypassed response first, then FIFO head, else NOP with zero PCs.
    always_comb begin
        instr_valid = 1'b0;
        Instr_F     = NOP_INSTR;
        PCF         = 32'h0000_0000;
        PCPlus4_F   = 32'h0000_0000;
        if (bypass_s) begin
            instr_valid = 1'b1;
            Instr_F     = imem_rsp_data;
            PCF         = rsp_pc_s;
            PCPlus4_F   = rsp_pc_s + 32'd4;
        end else if (fifo_nonempty_s) begin
            instr_valid = 1'b1;
            Instr_F     = instr_mem_r[rd_ptr_r];
            PCF         = pc_mem_r[rd_ptr_r];
            PCPlus4_F   = pc_mem_r[rd_ptr_r] + 32'd4;
        end else begin
            instr_valid = 1'b0;
            Instr_F     = NOP_INSTR;
            PCF         = 32'h0000_0000;
            PCPlus4_F   = 32'h0000_0000;
        end
    end

    // Fetch PC and outstanding-request bookkeeping; a redirect turns everything in flight into drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            inflight_r <= OUT_W'(0);
            drop_cnt_r <= OUT_W'(0);
        end else begin
            if (PCSrc) begin
                fetch_pc_r <= {PCTargetE[31:2], 2'b00};
            end else if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            case ({req_fire_s, imem_rsp_valid})
                2'b10:   inflight_r <= inflight_r + OUT_W'(1);
                2'b01:   inflight_r <= inflight_r - OUT_W'(1);
                default: inflight_r <= inflight_r;
            endcase

            if (PCSrc) begin
                drop_cnt_r <= inflight_r - OUT_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop_cnt_r != OUT_W'(0))) begin
                drop_cnt_r <= drop_cnt_r - OUT_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Instruction FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (PCSrc) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // PC-tag ring pointers; dropped responses have no tag since the ring is emptied on redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_wr_r <= TAG_W'(0);
            tag_rd_r <= TAG_W'(0);
        end else if (PCSrc) begin
            tag_wr_r <= TAG_W'(0);
            tag_rd_r <= TAG_W'(0);
        end else begin
            if (req_fire_s) begin
                tag_wr_r <= tag_next(tag_wr_r);
            end else begin
                tag_wr_r <= tag_wr_r;
            end
            if (rsp_live_s) begin
                tag_rd_r <= tag_next(tag_rd_r);
            end else begin
                tag_rd_r <= tag_rd_r;
            end
        end
    end

    // Data storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_rsp_data;
            pc_mem_r[wr_ptr_r]    <= rsp_pc_s;
        end
        if (req_fire_s) begin
            tag_mem_r[tag_wr_r] <= fetch_pc_r;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a 1-cycle-latency memory model with accept budget and response hold.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr_F;
    logic [31:0] PCF;
    logic [31:0] PCPlus4_F;
    logic        PCSrc;
    logic [31:0] PCTargetE;

    int          n_checks = 0;
    int          n_err    = 0;
    int          budget   = 0;
    int          n_acc    = 0;
    int          n0       = 0;
    logic        rsp_hold = 1'b0;
    logic        found;
    logic [31:0] exp_q[$];
    logic [31:0] req_exp_q[$];
    logic [31:0] acc_q[$];

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    fetch_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Instr_F(Instr_F),
        .PCF(PCF),
        .PCPlus4_F(PCPlus4_F),
        .PCSrc(PCSrc),
        .PCTargetE(PCTargetE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00A0_0093;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check({"drain_", name}, exp_q.size(), 32'd0);
    endtask

    // Memory model: records accepts at negedge, answers one cycle later in order.
    initial begin : mem_model
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (!reset && imem_req_valid && imem_req_ready) begin
                acc_q.push_back(imem_addr);
                budget = budget - 1;
                n_acc++;
                if (req_exp_q.size() == 0) begin
                    check("req_unexpected", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("req_addr", imem_addr, req_exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (reset) begin
                acc_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (!rsp_hold && acc_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(acc_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            imem_req_ready = !reset && (budget > 0);
        end
    end

    // Monitor: every consumed head is compared against the next expected PC.
    initial begin : monitor
        logic [31:0] pc;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready && !PCSrc) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", PCF, 32'hFFFF_FFFF);
                end else begin
                    pc = exp_q.pop_front();
                    check("PCF", PCF, pc);
                    check("Instr_F", Instr_F, mem_word(pc));
                    check("PCPlus4_F", PCPlus4_F, pc + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset       = 1'b1;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTargetE   = 32'h0000_0000;
        #3;
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_instr_valid", instr_valid, 32'd0);
        check("rst_Instr_F", Instr_F, 32'h0000_0013);
        check("rst_PCF", PCF, 32'd0);
        check("rst_PCPlus4_F", PCPlus4_F, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);

        // Sequential fetch with consumer always ready.
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        check("first_req_valid", imem_req_valid, 32'd1);
        check("first_req_addr", imem_addr, 32'h0000_0000);
        step();
        budget = 3;
        instr_ready = 1'b1;
        req_exp_q.push_back(32'h0000_0000); req_exp_q.push_back(32'h0000_0004); req_exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004); exp_q.push_back(32'h0000_0008);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_rsp_valid) found = 1'b1;
        end
        check("rsp_seen", found, 32'd1);
        check("valid_in_rsp_cycle", instr_valid, BYP);
        @(negedge clk);
        check("valid_after_rsp", instr_valid, 32'd1);
        wait_drain(40, "seq");

        // Stalled consumer: exactly DEPTH accepts, then one pop lets one more through.
        step();
        instr_ready = 1'b0;
        budget = 10;
        n0 = n_acc;
        req_exp_q.push_back(32'h0000_000C); req_exp_q.push_back(32'h0000_0010);
        req_exp_q.push_back(32'h0000_0014); req_exp_q.push_back(32'h0000_0018);
        repeat (10) step();
        @(negedge clk);
        check("full_accepts", n_acc - n0, 32'd4);
        check("full_req_valid", imem_req_valid, 32'd0);
        check("full_head_pc", PCF, 32'h0000_000C);
        step();
        exp_q.push_back(32'h0000_000C);
        req_exp_q.push_back(32'h0000_001C);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        @(negedge clk);
        check("refill_req_valid", imem_req_valid, 32'd1);
        check("refill_req_addr", imem_addr, 32'h0000_001C);
        repeat (4) step();
        @(negedge clk);
        check("refill_accepts", n_acc - n0, 32'd5);
        check("refill_req_blocked", imem_req_valid, 32'd0);
        step();
        budget = 0;
        instr_ready = 1'b1;
        exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h0000_0014);
        exp_q.push_back(32'h0000_0018); exp_q.push_back(32'h0000_001C);
        wait_drain(40, "full");

        // Redirect with two requests in flight: both responses dropped, target LSBs cleared.
        step();
        PCSrc = 1'b1;
        PCTargetE = 32'h0000_0010;
        @(negedge clk);
        check("redir_no_req", imem_req_valid, 32'd0);
        step();
        PCSrc = 1'b0;
        rsp_hold = 1'b1;
        budget = 2;
        req_exp_q.push_back(32'h0000_0010); req_exp_q.push_back(32'h0000_0014);
        repeat (6) step();
        @(negedge clk);
        check("held_instr_valid", instr_valid, 32'd0);
        step();
        PCSrc = 1'b1;
        PCTargetE = 32'h0000_0103;
        budget = 2;
        req_exp_q.push_back(32'h0000_0100); req_exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h0000_0104);
        step();
        PCSrc = 1'b0;
        rsp_hold = 1'b0;
        wait_drain(40, "redir");

        // Redirect colliding with a response and a pop.
        step();
        instr_ready = 1'b0;
        budget = 1;
        req_exp_q.push_back(32'h0000_0108);
        repeat (4) step();
        @(negedge clk);
        check("p4_head_valid", instr_valid, 32'd1);
        check("p4_head_pc", PCF, 32'h0000_0108);
        step();
        rsp_hold = 1'b1;
        budget = 2;
        req_exp_q.push_back(32'h0000_010C); req_exp_q.push_back(32'h0000_0110);
        repeat (5) step();
        step();
        rsp_hold = 1'b0;
        step();
        PCSrc = 1'b1;
        PCTargetE = 32'h0000_0200;
        instr_ready = 1'b1;
        rsp_hold = 1'b1;
        budget = 1;
        req_exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0200);
        @(negedge clk);
        check("p4_rsp_in_redirect", imem_rsp_valid, 32'd1);
        step();
        PCSrc = 1'b0;
        @(negedge clk);
        check("p4_flushed", instr_valid, 32'd0);
        step();
        rsp_hold = 1'b0;
        wait_drain(40, "collide");

        // Fetch PC wrap-around at the top of the address space.
        step();
        PCSrc = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        budget = 3;
        req_exp_q.push_back(32'hFFFF_FFF8); req_exp_q.push_back(32'hFFFF_FFFC); req_exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
        step();
        PCSrc = 1'b0;
        wait_drain(40, "wrap");
        repeat (3) step();
        check("req_queue_empty", req_exp_q.size(), 32'd0);

        // Reset in the middle of operation with a non-empty queue.
        instr_ready = 1'b0;
        budget = 2;
        req_exp_q.push_back(32'h0000_0004); req_exp_q.push_back(32'h0000_0008);
        repeat (5) step();
        @(negedge clk);
        check("pre_reset_valid", instr_valid, 32'd1);
        step();
        budget = 0;
        reset = 1'b1;
        req_exp_q.delete();
        exp_q.delete();
        #1;
        check("mid_rst_instr_valid", instr_valid, 32'd0);
        check("mid_rst_req_valid", imem_req_valid, 32'd0);
        check("mid_rst_PCF", PCF, 32'd0);
        check("mid_rst_Instr_F", Instr_F, 32'h0000_0013);
        check("mid_rst_imem_addr", imem_addr, 32'h0000_0000);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_valid", imem_req_valid, 32'd1);
        check("post_rst_req_addr", imem_addr, 32'h0000_0000);
        check("post_rst_instr_valid", instr_valid, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
